// File: rtl/marquee_pkg.sv
// marquee_pkg: shared types, constants and ring helpers for the hex_marquee slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package marquee_pkg;

  typedef logic [6:0] seg_t;     // one active-low seven-segment character
  typedef seg_t [3:0] word_t;    // [3] is the leftmost character

  typedef enum logic {
    BLANK  = 1'b0,
    SCROLL = 1'b1
  } state_t;

  localparam seg_t BLANK_SEG = 7'b1111111;
  localparam int   RING_LEN  = 10;

  // Ring slot shown by display k (0 = leftmost) at position p, wrapped to 0..9.
  // p <= 9 and k <= 5, so the sum never exceeds 14 and fits in 4 bits.
  function automatic logic [3:0] ring_idx(input logic [3:0] p, input logic [2:0] k);
    logic [3:0] s;
    s = p + {1'b0, k};
    return (s >= 4'(RING_LEN)) ? s - 4'(RING_LEN) : s;
  endfunction

  // Slots 0..3 carry word characters 3..0; the rest of the ring is blank.
  function automatic seg_t slot_seg(input word_t w, input logic [3:0] s);
    seg_t r;
    case (s)
      4'd0:    r = w[3];
      4'd1:    r = w[2];
      4'd2:    r = w[1];
      4'd3:    r = w[0];
      default: r = BLANK_SEG;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hex_marquee_if.sv
// hex_marquee_if: decoder word in, six seven-segment drives out.
// Ports: seg_in/word_valid/hold from the decoder side, HEX5..HEX0 to the displays.
// Backpressure: none; the word is level-sampled every clock.
interface hex_marquee_if;
  import marquee_pkg::*;

  word_t seg_in;      // four active-low characters, seg_in[3] leftmost
  logic  word_valid;  // decoder code is a defined item
  logic  hold;        // freeze scrolling
  seg_t  HEX5;
  seg_t  HEX4;
  seg_t  HEX3;
  seg_t  HEX2;
  seg_t  HEX1;
  seg_t  HEX0;

  modport master (
    output seg_in, word_valid, hold,
    input  HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );

  modport slave (
    input  seg_in, word_valid, hold,
    output HEX5, HEX4, HEX3, HEX2, HEX1, HEX0
  );

endinterface

// File: rtl/marquee_tick_gen.sv
// marquee_tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Ports: clk, reset_n (async active-low), clear (restart at 0), enable (count), tick.
// Latency: tick is combinational on the count, asserted while count = TICK_DIV-1; frozen when enable = 0.
module marquee_tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tick only fires while counting, so hold/BLANK also suppress steps.
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;   // clear wins over a coincident tick: full period follows
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_marquee.sv
// hex_marquee: scrolls a four-character segment word right-to-left over HEX5..HEX0.
// Ports: clk, reset_n (async active-low), bus (hex_marquee_if.slave).
// Latency: capture/reload visible one edge after sampling; outputs depend on registers only.
module hex_marquee
  import marquee_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic            clk,
  input  logic            reset_n,
  hex_marquee_if.slave    bus
);

  state_t     state_q, state_d;
  word_t      word_q, word_d;
  logic [3:0] p_q, p_d;

  logic tick;
  logic tick_clear;
  logic tick_en;

  seg_t disp [6];

  // Prescaler only runs while scrolling and not held.
  assign tick_en = (state_q == SCROLL) && !bus.hold;

  marquee_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tick_clear),
    .enable  (tick_en),
    .tick    (tick)
  );

  // Priority: word_valid = 0, then reload, then tick.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    p_d        = p_q;
    tick_clear = 1'b0;
    case (state_q)
      BLANK: begin
        if (bus.word_valid) begin
          word_d     = bus.seg_in;
          p_d        = 4'd0;
          tick_clear = 1'b1;
          state_d    = SCROLL;
        end
      end
      SCROLL: begin
        if (!bus.word_valid) begin
          word_d  = {4{BLANK_SEG}};
          p_d     = 4'd0;
          state_d = BLANK;
        end else if (bus.seg_in != word_q) begin
          word_d     = bus.seg_in;
          p_d        = 4'd0;
          tick_clear = 1'b1;
        end else if (tick) begin
          p_d = (p_q == 4'(RING_LEN - 1)) ? 4'd0 : p_q + 4'd1;
        end
      end
      default: begin
        state_d = BLANK;
        word_d  = {4{BLANK_SEG}};
        p_d     = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BLANK;
      word_q  <= {4{BLANK_SEG}};
      p_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      p_q     <= p_d;
    end
  end

  // Six slot-select muxes; display k shows ring slot (p+k) mod 10.
  // In BLANK word_q is all blank, so every slot resolves to BLANK_SEG.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      disp[k] = slot_seg(word_q, ring_idx(p_q, 3'(k)));
    end
  end

  assign bus.HEX5 = disp[0];
  assign bus.HEX4 = disp[1];
  assign bus.HEX3 = disp[2];
  assign bus.HEX2 = disp[3];
  assign bus.HEX1 = disp[4];
  assign bus.HEX0 = disp[5];

endmodule

// File: tb/tb_hex_marquee.sv
// tb_hex_marquee: directed bench for hex_marquee with TICK_DIV = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Expected display images are written out by hand per step.
module tb_hex_marquee;
  import marquee_pkg::*;

  localparam int TICK_DIV = 4;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  hex_marquee_if bus ();

  hex_marquee #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input seg_t e5, input seg_t e4, input seg_t e3,
                     input seg_t e2, input seg_t e1, input seg_t e0);
    logic [41:0] obs;
    logic [41:0] exp;
    obs = {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
    exp = {e5, e4, e3, e2, e1, e0};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  word_t w_bag;
  word_t w_dice;

  initial begin
    vectors     = 0;
    miscompares = 0;
    w_bag  = {7'h7F, 7'h00, 7'h08, 7'h42};
    w_dice = {7'h40, 7'h79, 7'h46, 7'h06};

    // Reset
    reset_n        = 1'b0;
    bus.seg_in     = w_bag;
    bus.word_valid = 1'b0;
    bus.hold       = 1'b0;
    step(2);
    chk("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    reset_n = 1'b1;
    step(20);
    chk("idle_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Capture " BAG"
    bus.word_valid = 1'b1;
    step(1);
    chk("capture_home", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);
    step(3);
    chk("before_step1", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);
    step(1);
    chk("step1", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);
    step(32);
    chk("pos9", 7'h7F, 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F);
    step(4);
    chk("wrap_home", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);

    // Reload mid-scroll after two steps
    step(8);
    chk("pos2", 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    step(1);
    bus.seg_in = w_dice;
    step(1);
    chk("reload_home", 7'h40, 7'h79, 7'h46, 7'h06, 7'h7F, 7'h7F);
    step(3);
    chk("reload_wait", 7'h40, 7'h79, 7'h46, 7'h06, 7'h7F, 7'h7F);
    step(1);
    chk("reload_step", 7'h79, 7'h46, 7'h06, 7'h7F, 7'h7F, 7'h7F);

    // Reload on the tick cycle: p must land on 0, not 1
    step(3);
    bus.seg_in = w_bag;
    step(1);
    chk("collide_home", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);
    step(3);
    chk("collide_wait", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);
    step(1);
    chk("collide_step", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);

    // Hold mid-period (prescaler at 2), release, step after 2 more edges
    step(2);
    bus.hold = 1'b1;
    step(5);
    chk("hold_mid", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);
    step(5);
    chk("hold_end", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);
    bus.hold = 1'b0;
    step(1);
    chk("resume_wait", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);
    step(1);
    chk("resume_step", 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Drop word_valid, then restore
    bus.word_valid = 1'b0;
    step(1);
    chk("blank_drop", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    bus.word_valid = 1'b1;
    step(1);
    chk("blank_restore", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);
    step(4);
    chk("restore_step", 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F, 7'h7F);

    // Asynchronous reset between edges
    step(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    bus.word_valid = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("post_reset_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    bus.word_valid = 1'b1;
    #1;
    chk("pre_sample_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    step(1);
    chk("post_reset_home", 7'h7F, 7'h00, 7'h08, 7'h42, 7'h7F, 7'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_marquee.md
# hex_marquee

Downstream stage of the item-code display decoder. Takes the four-character active-low segment word the decoder produces (HEX3..HEX0 patterns) and scrolls it right-to-left across all six DE1-SoC seven-segment displays (HEX5..HEX0). The scroll rate comes from a prescaler on the board clock. A new or changed word restarts the scroll from its home position.

## Interface
- TICK_DIV, 25_000_000: clock cycles per scroll step (0.5 s at 50 MHz); legal range ≥ 1; benches use 4.
- clk  input  1  board clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- seg_in  input  4x7  decoder word; seg_in[3] is the leftmost character; active-low segments.
- word_valid  input  1  1 when the decoder code is a defined item; 0 for undefined codes.
- hold  input  1  1 freezes scrolling. Reload and blanking still apply.
- HEX5..HEX0  output  7 each  active-low segment drives, HEX5 leftmost.

## Operation
- Ring of RING_LEN = 10 slots:
  - slots 0..3 = latched word characters 3..0;
  - slots 4..9 = BLANK_SEG (7'b1111111).
- Position register p, range 0..9. HEX5 shows slot p, HEX4 slot (p+1) mod 10, and so on down to HEX0, which shows slot (p+5) mod 10.
- States:
  - BLANK: all outputs BLANK_SEG and p = 0.
    - word_valid = 1 → capture seg_in into word_q, p = 0, prescaler = 0, go to SCROLL.
  - SCROLL: on each tick, if hold = 0, p = (p+1) mod 10, wrapping from 9 to 0.
    - word_valid = 0 → go to BLANK, clear word_q to BLANK_SEG.
    - word_valid = 1 and seg_in ≠ word_q → reload: capture seg_in, p = 0, prescaler = 0, stay in SCROLL.
- Tick: the prescaler counts 0..TICK_DIV-1 and asserts tick for one cycle when count = TICK_DIV-1, then returns to 0.
  - The prescaler is frozen while hold = 1 or the state is BLANK.
  - TICK_DIV = 1 gives a tick every cycle.
- Priority when events coincide: word_valid = 0 beats reload, reload beats tick. On a reload/tick collision, p ends at 0 and the prescaler at 0.
- Width rules:
  - prescaler width is $clog2(TICK_DIV), minimum 1;
  - p is 4 bits, with no values above 9 ever reachable.

## Timing
- Reset (asynchronous, any time, including mid-scroll):
  - state BLANK, p = 0, prescaler = 0, word_q = BLANK_SEG;
  - HEX5..HEX0 = 7'b1111111 immediately.
- Outputs are a function of registers only; there is no combinational path from seg_in, word_valid or hold to HEX outputs.
- Capture latency: word_valid/seg_in sampled at edge N → new display visible from edge N (one clock after the input change).
- Step period: exactly TICK_DIV cycles between p updates while hold = 0.
  - The first step comes TICK_DIV edges after a capture or reload.
- Hold:
  - asserting hold at edge N leaves p and the prescaler unchanged from edge N onward;
  - deasserting resumes counting from the frozen prescaler value.
- A full cycle of positions takes 10·TICK_DIV cycles, after which the display returns to the home image.

## Structure
- marquee_pkg holds:
  - BLANK_SEG = 7'b1111111;
  - RING_LEN = 10;
  - the state enum, state_t {BLANK, SCROLL};
  - a seg_t 7-bit typedef.
- One sub-module, marquee_tick_gen (parameter TICK_DIV; inputs clk, reset_n, clear, enable; output tick), holds the prescaler.
- The top module holds the FSM, word_q, p, and the six slot-select muxes.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset: hold reset_n = 0 → all HEX = 7F. Release with word_valid = 0 for 20 cycles → outputs stay 7F.
- Capture: seg_in = {7F,00,08,42} (" BAG"), word_valid = 1 → next edge HEX5..HEX0 = 7F,00,08,42,7F,7F. Four edges later → 00,08,42,7F,7F,7F. After 40 edges → home image again, confirming the wrap from 9 to 0.
- Reload mid-scroll: after 2 steps, switch seg_in to {40,79,46,06} ("DICE") → next edge HEX5..HEX0 = 40,79,46,06,7F,7F. The next step comes 4 edges later.
- Reload/tick collision: change seg_in on the cycle the tick fires → p = 0 and the full 4-cycle period follows.
- Hold: assert hold for 10 cycles mid-period → display frozen. After release, the step comes at the remaining count of the period.
- Blank and reset: drop word_valid → next edge all 7F. Restore it → home image. Pulse reset_n low mid-scroll between edges → all 7F asynchronously. After release, state stays BLANK until word_valid is sampled.
